// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths and opcode encoding.
// Imported by the alu and by the units that share it.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ALU_OP_W     = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU with zero flag.
// SLT is an unsigned compare; shift amount is b[4:0].
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] res,
  output logic            zero_flag
);

  always_comb begin
    res = '0;
    unique case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SLL: res = a << b[4:0];
      ALU_SRL: res = a >> b[4:0];
      ALU_SLT: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
  end

  assign zero_flag = (res == '0);

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible index after last_grant, wrapping.
// Purely combinational so it can front any shared unit.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_grant) + k;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!any && eligible[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NUM_REQ requesters, round-robin, one op/cycle.
// Each requester owns a one-entry registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*XLEN-1:0]     req_a,
  input  logic [NUM_REQ*XLEN-1:0]     req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ*XLEN-1:0]     rsp_res,
  output logic [NUM_REQ-1:0]          rsp_zero,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]                last_grant;
  logic [NUM_REQ-1:0]           elig;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           accept;
  logic [IW-1:0]                gidx;
  logic                         any;
  logic [NUM_REQ-1:0][XLEN-1:0] res_q;
  logic [NUM_REQ-1:0]           zero_q;
  logic [NUM_REQ-1:0]           valid_q;
  logic [XLEN-1:0]              a_sel;
  logic [XLEN-1:0]              b_sel;
  alu_op_t                      op_sel;
  logic [XLEN-1:0]              alu_res;
  logic                         alu_zero;

  // a slot being drained this cycle can be refilled this cycle
  assign elig = req_valid & (~valid_q | rsp_ready);

  rr_picker #(
    .N (NUM_REQ)
  ) u_pick (
    .eligible   (elig),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (gidx),
    .any        (any)
  );

  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign accept    = req_valid & req_ready;
  assign grant_idx = gidx;

  assign a_sel  = req_a[int'(gidx)*XLEN +: XLEN];
  assign b_sel  = req_b[int'(gidx)*XLEN +: XLEN];
  assign op_sel = alu_op_t'(req_op[int'(gidx)*ALU_OP_W +: ALU_OP_W]);

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a         (a_sel),
    .b         (b_sel),
    .op        (op_sel),
    .res       (alu_res),
    .zero_flag (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NUM_REQ - 1);
      res_q      <= '0;
      zero_q     <= '0;
      valid_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          res_q[i]   <= alu_res;
          zero_q[i]  <= alu_zero;
          valid_q[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (any) last_grant <= gidx;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_res   = res_q;
  assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases plus random traffic.
// Expected results come from an arithmetic reference and a rotation model.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int XL   = 32;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*XL-1:0]     req_a;
  logic [NREQ*XL-1:0]     req_b;
  logic [NREQ*3-1:0]      req_op;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*XL-1:0]     rsp_res;
  logic [NREQ-1:0]        rsp_zero;
  logic [$clog2(NREQ)-1:0] grant_idx;

  alu_arbiter #(.NUM_REQ(NREQ), .XLEN(XL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_zero  (rsp_zero),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [NREQ-1:0] v;
  logic [NREQ-1:0] rr;
  logic [NREQ-1:0] acc;
  logic [2:0]      op [NREQ];
  logic [31:0]     a  [NREQ];
  logic [31:0]     b  [NREQ];
  logic [32:0]     sbq [NREQ][$];
  logic [32:0]     last_res [NREQ];
  int              lg;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] alu_ref(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    logic [31:0] r;
    case (o)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << y[4:0];
      3'd6: r = x >> y[4:0];
      default: r = (x < y) ? 32'd1 : 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  task automatic put();
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*XL +: XL] = a[i];
      req_b[i*XL +: XL] = b[i];
      req_op[i*3 +: 3]  = op[i];
    end
  endtask

  // Expected grant: first requester after the last winner with a request
  // and a free (or just-drained) slot.
  task automatic score();
    logic [NREQ-1:0] exp_g;
    int g;
    g = -1;
    exp_g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (lg + k) % NREQ;
      if (g < 0 && v[j] && sbq[j].size() == 0) g = j;
    end
    if (g >= 0) exp_g[g] = 1'b1;
    chk("req_ready", req_ready, exp_g);
    acc = '0;
    if (g >= 0) begin
      chk("grant_idx", grant_idx, g);
      sbq[g].push_back(alu_ref(op[g], a[g], b[g]));
      lg = g;
      acc[g] = 1'b1;
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    put();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    score();
  endtask

  task automatic step();
    drive();
    settle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      sbq[i].delete();
      last_res[i] = '0;
    end
    lg  = NREQ - 1;
    acc = '0;
  endtask

  // Monitor: occupancy, result payload, and held value after drain.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("rsp_valid%0d", i), rsp_valid[i], sbq[i].size() != 0);
      if (sbq[i].size() != 0) begin
        chk($sformatf("rsp_res%0d", i), rsp_res[i*XL +: XL], sbq[i][0][31:0]);
        chk($sformatf("rsp_zero%0d", i), rsp_zero[i], sbq[i][0][32]);
        if (rsp_ready[i]) last_res[i] = sbq[i].pop_front();
      end else begin
        chk($sformatf("held_res%0d", i), rsp_res[i*XL +: XL], last_res[i][31:0]);
        chk($sformatf("held_zero%0d", i), rsp_zero[i], last_res[i][32]);
      end
    end
  end

  function automatic logic [31:0] rnd();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;
    v = '0;
    rr = '0;
    for (int i = 0; i < NREQ; i++) begin
      op[i] = '0;
      a[i]  = '0;
      b[i]  = '0;
    end
    model_reset();
    v = '1;
    put();
    #12;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_res", rsp_res, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_req_ready", req_ready, 0);
    v = '0;
    put();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // single add
    v = 2'b01; rr = 2'b11; op[0] = 3'd0; a[0] = 5; b[0] = 7;
    step();
    v = '0;
    drive();
    chk("t1_res", rsp_res[31:0], 32'd12);
    chk("t1_zero", rsp_zero[0], 1'b0);
    settle();

    // contention
    v = 2'b11; rr = 2'b11;
    op[0] = 3'd1; a[0] = 9; b[0] = 9;
    op[1] = 3'd7; a[1] = 3; b[1] = 8;
    repeat (4) step();
    v = '0;
    drive();
    chk("t2_res1", rsp_res[63:32], 32'd1);
    settle();

    // back-pressure on slot 0
    v = 2'b01; rr = 2'b10; op[0] = 3'd3; a[0] = 32'hAA; b[0] = 0;
    step();
    v = 2'b11; op[1] = 3'd5; a[1] = 1; b[1] = 32'h24;
    repeat (3) step();
    v = '0;
    drive();
    chk("t3_sll", rsp_res[63:32], 32'h10);
    chk("t3_held0", rsp_res[31:0], 32'hAA);
    settle();

    // drain and refill slot 0
    v = 2'b01; rr = 2'b11; op[0] = 3'd4; a[0] = 32'hF0; b[0] = 32'h0F;
    step();
    v = '0;
    drive();
    chk("t4_valid", rsp_valid[0], 1'b1);
    chk("t4_res", rsp_res[31:0], 32'hFF);
    settle();

    // wrap to zero
    v = 2'b10; op[1] = 3'd0; a[1] = 32'hFFFF_FFFF; b[1] = 1;
    step();
    v = '0;
    drive();
    chk("t5_res", rsp_res[63:32], 32'd0);
    chk("t5_zero", rsp_zero[1], 1'b1);
    settle();

    // random traffic; an unaccepted request is held stable
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(v[i] && !acc[i])) begin
          v[i]  = ($urandom_range(0, 3) != 0);
          op[i] = 3'($urandom_range(0, 7));
          a[i]  = rnd();
          b[i]  = rnd();
        end
      end
      rr = NREQ'($urandom);
      step();
    end
    v = '0; rr = '1;
    repeat (3) step();

    // reset with slot 1 occupied
    v = 2'b10; rr = 2'b00; op[1] = 3'd0; a[1] = 1; b[1] = 2;
    step();
    v = '0;
    drive();
    chk("t6_full", rsp_valid[1], 1'b1);
    settle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_cleared", rsp_valid, 0);
    chk("t6_ready_low", req_ready, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    v = 2'b11; rr = 2'b11;
    op[0] = 3'd2; a[0] = 32'hF0F0; b[0] = 32'hFF00;
    op[1] = 3'd6; a[1] = 32'h100; b[1] = 4;
    step();
    chk("t6_first_grant", req_ready, 2'b01);
    repeat (3) step();
    v = '0;
    repeat (3) step();
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("drained%0d", i), sbq[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
